// File: rtl/exc_commit_ctrl.sv
// Exception/interrupt commit controller for the M stage of the 5-stage MIPS pipeline.
// Arbitrates interrupts, M-stage exceptions and ERET; owns SR.EXL and the saved EPC.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_RUN     | normal execution, EXL=0, interrupts and exceptions taken
//   ST_HANDLER | inside handler, EXL=1, only nested exceptions or ERET
//   ST_GUARD   | one cycle after ERET, interrupts held off so EPC reaches M
module exc_commit_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Valid_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic        Eret_M,
  input  logic [5:0]  HWInt,
  input  logic [5:0]  IM,
  input  logic        IE,
  output logic        ActivateCP0,
  output logic        CoolCP0,
  output logic        Redirect,
  output logic [31:0] RedirectPC,
  output logic        EPC_We,
  output logic [31:0] EPC_Out,
  output logic        Cause_We,
  output logic [4:0]  ExcCode_Out,
  output logic        BD_Out,
  output logic [5:0]  IP_Out,
  output logic        EXL_Out
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_HANDLER = 2'd1;
  localparam logic [1:0] ST_GUARD   = 2'd2;

  localparam logic [4:0] CODE_RI = 5'd10;

  logic [1:0]  state;
  logic        exl;
  logic [31:0] epc_q;
  logic [5:0]  sync_q [SYNC_STAGES];

  logic        int_req;
  logic        exc_req;
  logic        ri_req;
  logic        ret_req;
  logic        take_int;
  logic        take_exc;
  logic        take_ret;
  logic        entry;
  logic [4:0]  entry_code;
  logic [31:0] epc_calc;

  // HWInt synchroniser chain; IP stays level-sensitive, nothing is latched as pending
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 6'd0;
    end else begin
      sync_q[0] <= HWInt;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign IP_Out  = sync_q[SYNC_STAGES-1];
  assign EXL_Out = exl;

  // Request terms and priority arbitration (interrupt > exception > return)
  always_comb begin
    int_req    = Valid_M & IE & ~exl & (|(IP_Out & IM));
    exc_req    = Valid_M & (ExcCode_M != 5'd0);
    ri_req     = Valid_M & Eret_M & ~exl;
    ret_req    = Valid_M & Eret_M & exl;
    take_int   = 1'b0;
    take_exc   = 1'b0;
    take_ret   = 1'b0;
    if (Rst) begin
      case (state)
        ST_RUN: begin
          if (int_req)                take_int = 1'b1;
          else if (exc_req || ri_req) take_exc = 1'b1;
        end
        ST_HANDLER: begin
          if (exc_req)      take_exc = 1'b1;
          else if (ret_req) take_ret = 1'b1;
        end
        ST_GUARD: begin
          if (exc_req || ri_req) take_exc = 1'b1;
        end
        default: ;
      endcase
    end
    entry      = take_int | take_exc;
    entry_code = take_int ? 5'd0 : (exc_req ? ExcCode_M : CODE_RI);
  end

  // A delay-slot instruction restarts at its branch
  assign epc_calc = BD_M ? (PC_M - 32'd4) : PC_M;

  assign ActivateCP0 = entry;
  assign CoolCP0     = take_ret;
  assign Redirect    = entry | take_ret;
  assign RedirectPC  = entry ? HANDLER_ADDR : (take_ret ? epc_q : 32'd0);
  assign EPC_We      = entry & ~exl;
  assign EPC_Out     = (entry & ~exl) ? epc_calc : 32'd0;
  assign Cause_We    = entry;
  assign ExcCode_Out = entry ? entry_code : 5'd0;
  assign BD_Out      = entry & BD_M;

  // FSM, EXL and saved EPC; nested entries keep the original EPC
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_RUN;
      exl   <= 1'b0;
      epc_q <= 32'd0;
    end else begin
      if (entry) begin
        if (!exl) epc_q <= epc_calc;
        exl   <= 1'b1;
        state <= ST_HANDLER;
      end else if (take_ret) begin
        exl   <= 1'b0;
        state <= ST_GUARD;
      end else begin
        case (state)
          ST_RUN:     state <= ST_RUN;
          ST_HANDLER: state <= ST_HANDLER;
          default:    state <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed scenarios then randomized traffic,
// all checked against a behavioural model of the commit rules.
module tb_exc_commit_ctrl;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Valid_M;
  logic [4:0]  ExcCode_M;
  logic [31:0] PC_M;
  logic        BD_M;
  logic        Eret_M;
  logic [5:0]  HWInt;
  logic [5:0]  IM;
  logic        IE;
  logic        ActivateCP0;
  logic        CoolCP0;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        EPC_We;
  logic [31:0] EPC_Out;
  logic        Cause_We;
  logic [4:0]  ExcCode_Out;
  logic        BD_Out;
  logic [5:0]  IP_Out;
  logic        EXL_Out;

  exc_commit_ctrl #(.HANDLER_ADDR(32'h0000_4180), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Rst(Rst), .Valid_M(Valid_M), .ExcCode_M(ExcCode_M), .PC_M(PC_M),
    .BD_M(BD_M), .Eret_M(Eret_M), .HWInt(HWInt), .IM(IM), .IE(IE),
    .ActivateCP0(ActivateCP0), .CoolCP0(CoolCP0), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .EPC_We(EPC_We), .EPC_Out(EPC_Out),
    .Cause_We(Cause_We), .ExcCode_Out(ExcCode_Out), .BD_Out(BD_Out),
    .IP_Out(IP_Out), .EXL_Out(EXL_Out)
  );

  always #5 Clk = ~Clk;

  localparam int NSYNC = 2;
  localparam int M_RUN = 0, M_HANDLER = 1, M_GUARD = 2;

  int checks = 0;
  int failures = 0;

  // reference model
  int          m_mode;
  logic        m_exl;
  logic [31:0] m_epc;
  logic [5:0]  m_ip;
  logic [5:0]  ip_q[$];
  logic        e_entry, e_ret;
  logic [4:0]  e_code;

  // last observed combinational values, for spot checks
  logic        last_act, last_cool, last_epc_we, last_cause_we, last_bd;
  logic [31:0] last_rpc, last_epc;
  logic [4:0]  last_code;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN;
    m_exl  = 1'b0;
    m_epc  = 32'd0;
    m_ip   = 6'd0;
    ip_q.delete();
    for (int i = 0; i < NSYNC - 1; i++) ip_q.push_back(6'd0);
  endtask

  task automatic compute();
    e_entry = 1'b0;
    e_ret   = 1'b0;
    e_code  = 5'd0;
    if (Rst && Valid_M) begin
      if (m_mode == M_RUN && IE && !m_exl && ((m_ip & IM) != 6'd0)) begin
        e_entry = 1'b1;
        e_code  = 5'd0;
      end else if (ExcCode_M != 5'd0) begin
        e_entry = 1'b1;
        e_code  = ExcCode_M;
      end else if (Eret_M && !m_exl) begin
        e_entry = 1'b1;
        e_code  = 5'd10;
      end else if (Eret_M && m_exl && m_mode == M_HANDLER) begin
        e_ret = 1'b1;
      end
    end
  endtask

  task automatic check_comb(input string ph);
    logic        we;
    logic [31:0] ev, rpc;
    compute();
    we  = e_entry && !m_exl;
    ev  = BD_M ? PC_M - 32'd4 : PC_M;
    rpc = e_entry ? 32'h0000_4180 : (e_ret ? m_epc : 32'd0);
    chk({ph, ".ActivateCP0"}, 32'(ActivateCP0), 32'(e_entry));
    chk({ph, ".CoolCP0"},     32'(CoolCP0),     32'(e_ret));
    chk({ph, ".Redirect"},    32'(Redirect),    32'(e_entry | e_ret));
    chk({ph, ".RedirectPC"},  RedirectPC,       rpc);
    chk({ph, ".EPC_We"},      32'(EPC_We),      32'(we));
    chk({ph, ".EPC_Out"},     EPC_Out,          we ? ev : 32'd0);
    chk({ph, ".Cause_We"},    32'(Cause_We),    32'(e_entry));
    chk({ph, ".ExcCode_Out"}, 32'(ExcCode_Out), 32'(e_entry ? e_code : 5'd0));
    chk({ph, ".BD_Out"},      32'(BD_Out),      32'(e_entry & BD_M));
    last_act = ActivateCP0; last_cool = CoolCP0; last_epc_we = EPC_We;
    last_cause_we = Cause_We; last_bd = BD_Out; last_rpc = RedirectPC;
    last_epc = EPC_Out; last_code = ExcCode_Out;
  endtask

  task automatic check_regs(input string ph);
    chk({ph, ".IP_Out"},  32'(IP_Out),  32'(m_ip));
    chk({ph, ".EXL_Out"}, 32'(EXL_Out), 32'(m_exl));
  endtask

  task automatic model_edge();
    if (!Rst) return;
    compute();
    if (e_entry) begin
      if (!m_exl) m_epc = BD_M ? PC_M - 32'd4 : PC_M;
      m_exl  = 1'b1;
      m_mode = M_HANDLER;
    end else if (e_ret) begin
      m_exl  = 1'b0;
      m_mode = M_GUARD;
    end else if (m_mode == M_GUARD) begin
      m_mode = M_RUN;
    end
    ip_q.push_back(HWInt);
    m_ip = ip_q.pop_front();
  endtask

  task automatic step(input string ph, input logic rst, input logic v, input logic [4:0] c,
                      input logic [31:0] pc, input logic bd, input logic er,
                      input logic [5:0] hw, input logic [5:0] im, input logic ie);
    @(negedge Clk);
    Rst = rst;
    if (!rst) model_reset();
    Valid_M = v; ExcCode_M = c; PC_M = pc; BD_M = bd; Eret_M = er;
    HWInt = hw; IM = im; IE = ie;
    #1 check_comb(ph);
    @(posedge Clk);
    model_edge();
    #1 check_regs(ph);
  endtask

  initial begin
    logic        r_rst, r_v, r_bd, r_er, r_ie;
    logic [4:0]  r_c;
    logic [5:0]  r_hw, r_im;
    logic [31:0] r_pc;

    Rst = 1'b0; Valid_M = 0; ExcCode_M = 0; PC_M = 0; BD_M = 0; Eret_M = 0;
    HWInt = 0; IM = 0; IE = 0;
    model_reset();

    // 1: reset, then idle
    step("t1_rst", 1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("t1_rst", 1'b0, 1, 5'd4, 32'h100, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("t1_idle", 1'b1, 0, 0, 0, 0, 0, 0, 0, 0);

    // 2: interrupt entry after synchroniser latency
    step("t2_bub", 1'b1, 0, 0, 0, 0, 0, 6'h04, 6'h04, 1);
    step("t2_bub", 1'b1, 0, 0, 0, 0, 0, 6'h04, 6'h04, 1);
    chk("t2_ip_lat", 32'(IP_Out), 32'h04);
    step("t2_int", 1'b1, 1, 0, 32'h3010, 0, 0, 6'h04, 6'h04, 1);
    chk("t2_act", 32'(last_act), 32'd1);
    chk("t2_rpc", last_rpc, 32'h0000_4180);
    chk("t2_epc", last_epc, 32'h3010);
    chk("t2_code", 32'(last_code), 32'd0);
    chk("t2_exl", 32'(EXL_Out), 32'd1);
    step("t2_h", 1'b1, 0, 0, 0, 0, 0, 0, 6'h04, 1);
    step("t2_h", 1'b1, 0, 0, 0, 0, 0, 0, 6'h04, 1);
    step("t2_eret", 1'b1, 1, 0, 32'h4190, 0, 1, 0, 6'h04, 1);
    chk("t2_ret_rpc", last_rpc, 32'h3010);
    step("t2_guard", 1'b1, 1, 0, 32'h3010, 0, 0, 0, 6'h04, 1);

    // 3: AdEL in a delay slot, then ERET
    step("t3_exc", 1'b1, 1, 5'd4, 32'h3008, 1, 0, 0, 6'h04, 1);
    chk("t3_epc", last_epc, 32'h3004);
    chk("t3_bd", 32'(last_bd), 32'd1);
    chk("t3_code", 32'(last_code), 32'd4);
    step("t3_eret", 1'b1, 1, 0, 32'h4180, 0, 1, 0, 6'h04, 1);
    chk("t3_cool", 32'(last_cool), 32'd1);
    chk("t3_rpc", last_rpc, 32'h3004);
    chk("t3_exl", 32'(EXL_Out), 32'd0);
    step("t3_guard", 1'b1, 0, 0, 0, 0, 0, 0, 6'h04, 1);

    // 4: interrupt beats exception; nested exception keeps EPC
    step("t4_bub", 1'b1, 0, 0, 0, 0, 0, 6'h04, 6'h04, 1);
    step("t4_bub", 1'b1, 0, 0, 0, 0, 0, 6'h04, 6'h04, 1);
    step("t4_both", 1'b1, 1, 5'd12, 32'h3020, 0, 0, 6'h04, 6'h04, 1);
    chk("t4_code", 32'(last_code), 32'd0);
    step("t4_nest", 1'b1, 1, 5'd8, 32'h5000, 0, 0, 0, 6'h04, 1);
    chk("t4_cause_we", 32'(last_cause_we), 32'd1);
    chk("t4_epc_we", 32'(last_epc_we), 32'd0);
    step("t4_h", 1'b1, 0, 0, 0, 0, 0, 0, 6'h04, 1);
    step("t4_h", 1'b1, 0, 0, 0, 0, 0, 0, 6'h04, 1);
    step("t4_eret", 1'b1, 1, 0, 32'h5004, 0, 1, 0, 6'h04, 1);
    chk("t4_rpc", last_rpc, 32'h3020);
    step("t4_guard", 1'b1, 0, 0, 0, 0, 0, 0, 6'h04, 1);

    // 5: ERET with EXL=0 is RI; interrupt held through ERET is deferred by GUARD
    step("t5_ri", 1'b1, 1, 0, 32'h3030, 0, 1, 0, 6'h04, 1);
    chk("t5_code", 32'(last_code), 32'd10);
    chk("t5_cool", 32'(last_cool), 32'd0);
    step("t5_h", 1'b1, 0, 0, 0, 0, 0, 6'h04, 6'h04, 1);
    step("t5_h", 1'b1, 0, 0, 0, 0, 0, 6'h04, 6'h04, 1);
    step("t5_eret", 1'b1, 1, 0, 32'h4184, 0, 1, 6'h04, 6'h04, 1);
    step("t5_guard", 1'b1, 1, 0, 32'h3030, 0, 0, 6'h04, 6'h04, 1);
    chk("t5_guard_act", 32'(last_act), 32'd0);
    step("t5_int", 1'b1, 1, 0, 32'h3034, 0, 0, 6'h04, 6'h04, 1);
    chk("t5_int_act", 32'(last_act), 32'd1);

    // 6: asynchronous reset mid-cycle while in HANDLER
    @(negedge Clk);
    Valid_M = 1; ExcCode_M = 5'd8; PC_M = 32'h4188; BD_M = 0; Eret_M = 0;
    #1 check_comb("t6_pre");
    #2 Rst = 1'b0;
    model_reset();
    #1 check_comb("t6_async");
    chk("t6_exl", 32'(EXL_Out), 32'd0);
    chk("t6_we", 32'(Cause_We | EPC_We | ActivateCP0 | CoolCP0), 32'd0);
    @(posedge Clk);
    #1 check_regs("t6_post");
    step("t6_rel", 1'b1, 0, 0, 0, 0, 0, 0, 6'h04, 1);

    // randomized traffic
    r_hw = 6'd0; r_im = 6'h3f;
    for (int i = 0; i < 800; i++) begin
      r_rst = ($urandom_range(0, 99) != 0);
      r_v   = ($urandom_range(0, 3) != 0);
      r_c   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      r_er  = ($urandom_range(0, 5) == 0);
      r_bd  = 1'($urandom_range(0, 1));
      r_ie  = ($urandom_range(0, 9) < 7);
      r_pc  = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) r_hw = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) r_im = 6'($urandom_range(0, 63));
      step("rnd", r_rst, r_v, r_c, r_pc, r_bd, r_er, r_hw, r_im, r_ie);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
